// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame controller.
//   SYNC_BYTE    - first byte of every frame
//   CMD_SETBAUD  - reserved command that reprograms the receiver baudrate
//   state_e      - frame assembly states
//   ERR_*        - bit positions inside err_flags
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h55;
  localparam logic [7:0] CMD_SETBAUD = 8'hB0;
  localparam logic [4:0] SETBAUD_LEN = 5'd4;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    LEN,
    PAYLOAD,
    CSUM,
    HOLD
  } state_e;

  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAME   = 1;  // checksum mismatch, bad length, zero baud
  localparam int ERR_TIMEOUT = 2;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Host-side frame handshake and payload read port.
//   frm_valid/frm_cmd/frm_len : held frame, controller -> host
//   frm_ack                   : host consumed the frame
//   rd_addr/rd_data           : combinational payload buffer read
// master = controller side, slave = host side.
interface uart_rx_frame_ctrl_if;
  logic       frm_valid;
  logic [7:0] frm_cmd;
  logic [4:0] frm_len;
  logic       frm_ack;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output frm_valid, frm_cmd, frm_len, rd_data,
    input  frm_ack, rd_addr
  );

  modport slave (
    input  frm_valid, frm_cmd, frm_len, rd_data,
    output frm_ack, rd_addr
  );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one combinational read port. Contents are intentionally not reset.
//   clk      in  system clock
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data (combinational)
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller between uart_rx and the host. Drives the receiver
// configuration and assembles SYNC/CMD/LEN/PAYLOAD/CSUM frames; good frames
// are held for the host until acknowledged. Command CMD_SETBAUD with a
// 4-byte payload reprograms the baudrate instead of being presented.
//   clk, rst                  clock, synchronous active-high reset
//   rx_ready/rx_data/rx_parity_valid  byte strobe from uart_rx
//   cfg_*                     configuration to uart_rx
//   frm (master)              held frame + payload read port
//   err_flags, drop_cnt       sticky status, cleared by err_clr
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 25000000,
  parameter int DEFAULT_BAUD = 115200,
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CYC  = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_parity_valid,
  output logic [31:0] cfg_baudrate,
  output logic [1:0]  cfg_stop_bits,
  output logic        cfg_parity_en,
  output logic        cfg_parity_type,
  output logic        cfg_rx_en,
  uart_rx_frame_ctrl_if.master frm,
  output logic [2:0]  err_flags,
  output logic [7:0]  drop_cnt,
  input  logic        err_clr
);

  // A non-positive timeout falls back to roughly one millisecond.
  localparam int TIMEOUT_EFF = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC : (CLK_HZ / 1000);
  localparam int IDLE_W = $clog2(TIMEOUT_EFF + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_EFF - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [4:0]        len_q, len_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       baud_sh_q, baud_sh_d;
  logic [31:0]       baud_q, baud_d;
  logic              rx_en_q, rx_en_d;
  logic              frm_valid_q, frm_valid_d;
  logic [7:0]        frm_cmd_q, frm_cmd_d;
  logic [4:0]        frm_len_q, frm_len_d;
  logic [2:0]        err_q, err_d;
  logic [7:0]        drop_q, drop_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [2:0]        new_err;
  logic              drop_evt;
  logic              buf_we;

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(4)) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (rx_data),
    .raddr_i (frm.rd_addr),
    .rdata_o (frm.rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      cmd_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      baud_sh_q   <= '0;
      baud_q      <= 32'(DEFAULT_BAUD);
      rx_en_q     <= 1'b1;
      frm_valid_q <= 1'b0;
      frm_cmd_q   <= '0;
      frm_len_q   <= '0;
      err_q       <= '0;
      drop_q      <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      baud_sh_q   <= baud_sh_d;
      baud_q      <= baud_d;
      rx_en_q     <= rx_en_d;
      frm_valid_q <= frm_valid_d;
      frm_cmd_q   <= frm_cmd_d;
      frm_len_q   <= frm_len_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      idle_q      <= idle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    baud_sh_d   = baud_sh_q;
    baud_d      = baud_q;
    rx_en_d     = 1'b1;
    frm_valid_d = frm_valid_q;
    frm_cmd_d   = frm_cmd_q;
    frm_len_d   = frm_len_q;
    idle_d      = idle_q;
    new_err     = '0;
    drop_evt    = 1'b0;
    buf_we      = 1'b0;

    // Inter-byte idle timer, only armed while a frame is in progress.
    if (rx_ready) begin
      idle_d = '0;
    end else if (state_q inside {CMD, LEN, PAYLOAD, CSUM}) begin
      if (idle_q == IDLE_LAST) begin
        idle_d               = '0;
        new_err[ERR_TIMEOUT] = 1'b1;
        state_d              = HUNT;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end

    if (rx_ready) begin
      if (state_q == HOLD) begin
        drop_evt = 1'b1;
      end else if (!rx_parity_valid) begin
        // Bad byte is never interpreted, not even as a sync byte.
        new_err[ERR_PARITY] = 1'b1;
        state_d             = HUNT;
      end else begin
        case (state_q)
          HUNT: begin
            if (rx_data == SYNC_BYTE) state_d = CMD;
          end
          CMD: begin
            cmd_d   = rx_data;
            csum_d  = rx_data;
            state_d = LEN;
          end
          LEN: begin
            if (rx_data > MAX_LEN_B) begin
              new_err[ERR_FRAME] = 1'b1;
              state_d            = HUNT;
            end else begin
              len_d   = rx_data[4:0];
              csum_d  = csum_q ^ rx_data;
              idx_d   = '0;
              state_d = (rx_data == 8'd0) ? CSUM : PAYLOAD;
            end
          end
          PAYLOAD: begin
            buf_we    = 1'b1;
            csum_d    = csum_q ^ rx_data;
            idx_d     = idx_q + 1'b1;
            // Last four payload bytes, big-endian; equals buf[0..3] when len=4.
            baud_sh_d = {baud_sh_q[23:0], rx_data};
            if ({1'b0, idx_q} == len_q - 5'd1) state_d = CSUM;
          end
          CSUM: begin
            state_d = HUNT;
            if (rx_data != csum_q) begin
              new_err[ERR_FRAME] = 1'b1;
            end else if (cmd_q == CMD_SETBAUD && len_q == SETBAUD_LEN) begin
              if (baud_sh_q == 32'd0) begin
                new_err[ERR_FRAME] = 1'b1;
              end else begin
                baud_d  = baud_sh_q;
                rx_en_d = 1'b0;  // one-cycle re-enable so uart_rx picks up the new rate
              end
            end else begin
              frm_valid_d = 1'b1;
              frm_cmd_d   = cmd_q;
              frm_len_d   = len_q;
              state_d     = HOLD;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end

    if (state_q == HOLD && frm.frm_ack) begin
      frm_valid_d = 1'b0;
      state_d     = HUNT;
    end

    // A clear in the same cycle as a new event keeps the new event.
    err_d  = (err_clr ? 3'b000 : err_q) | new_err;
    drop_d = err_clr ? 8'd0 : drop_q;
    if (drop_evt && drop_d != 8'hFF) drop_d = drop_d + 8'd1;
  end

  assign cfg_baudrate    = baud_q;
  assign cfg_stop_bits   = 2'd0;
  assign cfg_parity_en   = 1'b1;
  assign cfg_parity_type = 1'b0;
  assign cfg_rx_en       = rx_en_q;
  assign frm.frm_valid   = frm_valid_q;
  assign frm.frm_cmd     = frm_cmd_q;
  assign frm.frm_len     = frm_len_q;
  assign err_flags       = err_q;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: a vector table of frames plus
// hand-written sequences for baud reprogramming, parity, timeout, drop
// counting and simultaneous events. Expected frames go through a queue.
module tb_uart_rx_frame_ctrl;

  localparam int TO_CYC = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_parity_valid = 1'b1;
  logic        err_clr = 1'b0;
  logic [31:0] cfg_baudrate;
  logic [1:0]  cfg_stop_bits;
  logic        cfg_parity_en;
  logic        cfg_parity_type;
  logic        cfg_rx_en;
  logic [2:0]  err_flags;
  logic [7:0]  drop_cnt;

  uart_rx_frame_ctrl_if ifc ();

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .CLK_HZ(25000000), .DEFAULT_BAUD(115200), .MAX_LEN(16), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_ready        (rx_ready),
    .rx_data         (rx_data),
    .rx_parity_valid (rx_parity_valid),
    .cfg_baudrate    (cfg_baudrate),
    .cfg_stop_bits   (cfg_stop_bits),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_parity_type (cfg_parity_type),
    .cfg_rx_en       (cfg_rx_en),
    .frm             (ifc),
    .err_flags       (err_flags),
    .drop_cnt        (drop_cnt),
    .err_clr         (err_clr)
  );

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] pl [16];
  } frame_t;

  typedef struct {
    frame_t     f;
    bit         corrupt;
    bit         exp_valid;
    logic [2:0] exp_err;
  } vec_t;

  frame_t exp_q [$];
  vec_t   vecs [7];
  int     n_cmp  = 0;
  int     n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] calc_csum(input frame_t f);
    logic [7:0] c;
    c = f.cmd ^ f.len;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(f.len)) c = c ^ f.pl[i];
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic par = 1'b1);
    @(negedge clk);
    rx_ready        = 1'b1;
    rx_data         = b;
    rx_parity_valid = par;
    @(negedge clk);
    rx_ready        = 1'b0;
    rx_parity_valid = 1'b1;
  endtask

  task automatic send_frame(input frame_t f, input bit corrupt, input bit expect_good);
    logic [7:0] c;
    send_byte(8'h55);
    send_byte(f.cmd);
    send_byte(f.len);
    if (f.len <= 8'd16) begin
      for (int i = 0; i < int'(f.len); i++) send_byte(f.pl[i]);
      c = calc_csum(f);
      if (corrupt) c = ~c;
      if (expect_good) exp_q.push_back(f);
      send_byte(c);
    end
  endtask

  // Called right after the checksum strobe: the frame must already be held.
  task automatic check_frame(input bit do_ack);
    frame_t e;
    chk("frm_valid", 32'(ifc.frm_valid), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: got a frame, expected queue empty");
    end else begin
      e = exp_q.pop_front();
      chk("frm_cmd", 32'(ifc.frm_cmd), 32'(e.cmd));
      chk("frm_len", 32'(ifc.frm_len), 32'(e.len));
      for (int i = 0; i < int'(e.len); i++) begin
        ifc.rd_addr = 4'(i);
        #1;
        chk("rd_data", 32'(ifc.rd_data), 32'(e.pl[i]));
      end
      $display("frame cmd=%02h len=%0d checked", e.cmd, e.len);
    end
    if (do_ack) begin
      @(negedge clk);
      ifc.frm_ack = 1'b1;
      @(negedge clk);
      ifc.frm_ack = 1'b0;
      chk("frm_valid_after_ack", 32'(ifc.frm_valid), 32'd0);
    end
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err_flags), 32'd0);
    chk("drop_cleared", 32'(drop_cnt), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    frame_t f;

    ifc.frm_ack = 1'b0;
    ifc.rd_addr = 4'd0;

    // Vector table: frame contents, corruption, expected outcome.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 16; i++) vecs[v].f.pl[i] = 8'(i * 37 + v + 1);
      vecs[v].corrupt   = 1'b0;
      vecs[v].exp_valid = 1'b1;
      vecs[v].exp_err   = 3'b000;
    end
    vecs[0].f.cmd = 8'h10; vecs[0].f.len = 8'd2; vecs[0].f.pl[0] = 8'hAA; vecs[0].f.pl[1] = 8'hBB;
    vecs[1].f = vecs[0].f; vecs[1].corrupt = 1'b1; vecs[1].exp_valid = 1'b0; vecs[1].exp_err = 3'b010;
    vecs[2].f.cmd = 8'h20; vecs[2].f.len = 8'd0;
    vecs[3].f.cmd = 8'h33; vecs[3].f.len = 8'd16;
    vecs[4].f.cmd = 8'h44; vecs[4].f.len = 8'd1; vecs[4].f.pl[0] = 8'h5A;
    vecs[5].f.cmd = 8'hB0; vecs[5].f.len = 8'd3;
    vecs[6].f.cmd = 8'h66; vecs[6].f.len = 8'd17; vecs[6].exp_valid = 1'b0; vecs[6].exp_err = 3'b010;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_baud", cfg_baudrate, 32'd115200);
    chk("rst_rx_en", 32'(cfg_rx_en), 32'd1);
    chk("rst_valid", 32'(ifc.frm_valid), 32'd0);
    chk("rst_cmd", 32'(ifc.frm_cmd), 32'd0);
    chk("rst_len", 32'(ifc.frm_len), 32'd0);
    chk("rst_err", 32'(err_flags), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("cfg_stop", 32'(cfg_stop_bits), 32'd0);
    chk("cfg_par_en", 32'(cfg_parity_en), 32'd1);
    chk("cfg_par_type", 32'(cfg_parity_type), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].f, vecs[v].corrupt, vecs[v].exp_valid);
      if (vecs[v].exp_valid) check_frame(1'b1);
      else chk("no_frame", 32'(ifc.frm_valid), 32'd0);
      chk("vec_err", 32'(err_flags), 32'(vecs[v].exp_err));
      $display("vector %0d cmd=%02h len=%0d err=%03b", v, vecs[v].f.cmd, vecs[v].f.len, err_flags);
      clear_err();
    end

    // Baud reprogramming: 0x0000E100 = 57600
    f.cmd = 8'hB0; f.len = 8'd4;
    for (int i = 0; i < 16; i++) f.pl[i] = 8'h00;
    f.pl[2] = 8'hE1;
    send_frame(f, 1'b0, 1'b0);
    chk("baud_set", cfg_baudrate, 32'd57600);
    chk("rx_en_low", 32'(cfg_rx_en), 32'd0);
    chk("baud_no_frame", 32'(ifc.frm_valid), 32'd0);
    @(negedge clk);
    chk("rx_en_high", 32'(cfg_rx_en), 32'd1);
    chk("baud_err", 32'(err_flags), 32'd0);
    $display("setbaud 57600 applied");
    f.pl[2] = 8'h00;
    send_frame(f, 1'b0, 1'b0);
    chk("baud_zero_kept", cfg_baudrate, 32'd57600);
    chk("baud_zero_err", 32'(err_flags), 32'b010);
    $display("setbaud 0 rejected");
    clear_err();
    pulse_reset();
    chk("baud_reset", cfg_baudrate, 32'd115200);

    // Parity error mid-frame, then normal frame
    send_byte(8'h55);
    send_byte(8'h10, 1'b0);
    chk("parity_err", 32'(err_flags), 32'b001);
    f.cmd = 8'h21; f.len = 8'd0;
    send_frame(f, 1'b0, 1'b1);
    check_frame(1'b1);
    // Sync byte with bad parity is not a sync byte
    send_byte(8'h55, 1'b0);
    send_byte(8'h21); send_byte(8'h00); send_byte(8'h21);
    chk("parity_no_sync", 32'(ifc.frm_valid), 32'd0);
    $display("parity sequence done");
    clear_err();

    // Timeout after 55 10
    send_byte(8'h55);
    send_byte(8'h10);
    repeat (TO_CYC - 3) @(negedge clk);
    chk("timeout_early", 32'(err_flags), 32'd0);
    repeat (6) @(negedge clk);
    chk("timeout_err", 32'(err_flags), 32'b100);
    send_frame(f, 1'b0, 1'b1);
    check_frame(1'b1);
    $display("timeout sequence done");
    clear_err();

    // err_clr together with a new error: new error wins
    send_frame(vecs[0].f, 1'b1, 1'b0);
    send_byte(8'h55);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'h10; rx_parity_valid = 1'b0; err_clr = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; rx_parity_valid = 1'b1; err_clr = 1'b0;
    chk("clr_vs_err", 32'(err_flags), 32'b001);
    $display("clear vs error done");
    clear_err();

    // Held frame, 300 dropped bytes, saturating counter
    send_frame(vecs[0].f, 1'b0, 1'b1);
    check_frame(1'b0);
    for (int i = 0; i < 300; i++) send_byte(8'($urandom), 1'($urandom));
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    chk("hold_valid", 32'(ifc.frm_valid), 32'd1);
    chk("hold_cmd", 32'(ifc.frm_cmd), 32'h10);
    chk("hold_len", 32'(ifc.frm_len), 32'd2);
    ifc.rd_addr = 4'd0; #1;
    chk("hold_rd0", 32'(ifc.rd_data), 32'hAA);
    ifc.rd_addr = 4'd1; #1;
    chk("hold_rd1", 32'(ifc.rd_data), 32'hBB);
    chk("hold_err", 32'(err_flags), 32'd0);
    $display("drop saturation done");
    clear_err();

    // Ack together with a byte: byte dropped, back to HUNT
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'h55; ifc.frm_ack = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; ifc.frm_ack = 1'b0;
    chk("ack_rx_valid", 32'(ifc.frm_valid), 32'd0);
    chk("ack_rx_drop", 32'(drop_cnt), 32'd1);
    send_byte(8'h21); send_byte(8'h00); send_byte(8'h21);
    chk("ack_rx_hunt", 32'(ifc.frm_valid), 32'd0);
    $display("ack with byte done");
    clear_err();

    // Reset mid-frame aborts it
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA);
    pulse_reset();
    send_byte(8'hBB); send_byte(8'h03);
    chk("rst_mid_frame", 32'(ifc.frm_valid), 32'd0);
    $display("reset mid-frame done");

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d pending frames, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
